// File: rtl/axis_byte_count_ctrl.sv
// Transparent AXI-Stream tap that measures beats, kept bytes and packets
// over a programmed number of whole packets, then holds a valid/ready report.
//
// Ports:
//   aclk, rst             clock, synchronous active-high reset
//   s_axis_* / m_axis_*   upstream / downstream stream (combinational passthrough)
//   cfg_start             arm request (IDLE only); samples cfg_num_packets
//   cfg_abort             drop an armed or running window without reporting
//   cfg_num_packets       packets per measurement window
//   busy                  window armed or counting
//   res_valid/res_ready   report handshake
//   res_bytes/res_beats   saturating byte and beat counts
//   res_packets           tlast beats counted
//   res_overflow          sticky: a beat or byte counter saturated
module axis_byte_count_ctrl #(
  parameter int AXIS_BYTES   = 4,
  parameter int COUNTER_BITS = 32,
  parameter int PKT_BITS     = 8
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [AXIS_BYTES*8-1:0]   s_axis_tdata,
  input  logic [AXIS_BYTES-1:0]     s_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [AXIS_BYTES*8-1:0]   m_axis_tdata,
  output logic [AXIS_BYTES-1:0]     m_axis_tkeep,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic [PKT_BITS-1:0]       cfg_num_packets,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [COUNTER_BITS-1:0]   res_bytes,
  output logic [COUNTER_BITS-1:0]   res_beats,
  output logic [PKT_BITS-1:0]       res_packets,
  output logic                      res_overflow
);

  localparam int KW = $clog2(AXIS_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNT,
    REPORT
  } state_t;

  state_t                  state;
  logic                    in_pkt;
  logic [PKT_BITS-1:0]     num_pkts;

  logic                    accept;
  logic                    sop;
  logic [KW-1:0]           keep_cnt;
  logic [COUNTER_BITS:0]   bytes_sum;
  logic [COUNTER_BITS-1:0] bytes_nxt;
  logic                    beats_max;
  logic [COUNTER_BITS-1:0] beats_nxt;
  logic                    ovf_nxt;
  logic [PKT_BITS-1:0]     pkts_nxt;
  logic                    last_pkt;

  // The tap never stalls the stream, in any state or during reset.
  assign s_axis_tready = m_axis_tready;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign accept = s_axis_tvalid && m_axis_tready;
  assign sop    = accept && !in_pkt;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      keep_cnt = keep_cnt + KW'(s_axis_tkeep[i]);
    end
  end

  // One extra bit on the byte sum catches carry-out for saturation.
  assign bytes_sum = {1'b0, res_bytes}
                   + {{(COUNTER_BITS + 1 - KW){1'b0}}, keep_cnt};
  assign bytes_nxt = bytes_sum[COUNTER_BITS] ? '1
                   : bytes_sum[COUNTER_BITS-1:0];

  assign beats_max = &res_beats;
  assign beats_nxt = beats_max ? res_beats
                   : res_beats + COUNTER_BITS'(1);

  assign ovf_nxt   = res_overflow
                   | bytes_sum[COUNTER_BITS]
                   | beats_max;

  assign pkts_nxt  = res_packets + PKT_BITS'(s_axis_tlast);
  assign last_pkt  = s_axis_tlast && (pkts_nxt == num_pkts);

  always_ff @(posedge aclk) begin
    if (rst) begin
      state        <= IDLE;
      in_pkt       <= 1'b0;
      num_pkts     <= '0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_bytes    <= '0;
      res_beats    <= '0;
      res_packets  <= '0;
      res_overflow <= 1'b0;
    end else begin
      if (accept) begin
        in_pkt <= !s_axis_tlast;
      end

      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            num_pkts     <= cfg_num_packets;
            res_bytes    <= '0;
            res_beats    <= '0;
            res_packets  <= '0;
            res_overflow <= 1'b0;
            if (cfg_num_packets == '0) begin
              state     <= REPORT;
              res_valid <= 1'b1;
            end else begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
        end

        ARMED: begin
          if (cfg_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sop) begin
            // Counters were cleared at start, so the running
            // next-values equal this first beat alone.
            res_bytes    <= bytes_nxt;
            res_beats    <= beats_nxt;
            res_packets  <= pkts_nxt;
            res_overflow <= ovf_nxt;
            if (last_pkt) begin
              state     <= REPORT;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end

        COUNT: begin
          if (cfg_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            res_bytes    <= bytes_nxt;
            res_beats    <= beats_nxt;
            res_packets  <= pkts_nxt;
            res_overflow <= ovf_nxt;
            if (last_pkt) begin
              state     <= REPORT;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end

        REPORT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_byte_count_ctrl.sv
// Directed bench for axis_byte_count_ctrl: scoreboarded reports,
// passthrough mirror monitor, saturation on a narrow-counter instance.
module tb_axis_byte_count_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, m_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        cfg_start, cfg_start2, cfg_abort;
  logic [7:0]  cfg_num;
  logic        busy, res_valid, res_ready;
  logic [31:0] res_bytes, res_beats;
  logic [7:0]  res_packets;
  logic        res_overflow;

  logic        s_tready2, m_tvalid2, m_tlast2;
  logic [31:0] m_tdata2;
  logic [3:0]  m_tkeep2;
  logic        busy2, res_valid2, res_overflow2;
  logic [3:0]  res_bytes2, res_beats2;
  logic [7:0]  res_packets2;

  int n_cmp = 0;
  int n_err = 0;
  bit stall = 0;

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] beats;
    logic [7:0]  pkts;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  axis_byte_count_ctrl dut (
    .aclk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_packets(cfg_num),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_bytes(res_bytes), .res_beats(res_beats),
    .res_packets(res_packets), .res_overflow(res_overflow)
  );

  axis_byte_count_ctrl #(.COUNTER_BITS(4)) dut4 (
    .aclk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
    .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast2), .m_axis_tdata(m_tdata2),
    .m_axis_tkeep(m_tkeep2),
    .cfg_start(cfg_start2), .cfg_abort(cfg_abort),
    .cfg_num_packets(cfg_num),
    .busy(busy2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_bytes(res_bytes2), .res_beats(res_beats2),
    .res_packets(res_packets2), .res_overflow(res_overflow2)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Passthrough must mirror the stream every cycle.
  always @(negedge clk) begin
    chk("pt_valid", m_tvalid, s_tvalid);
    chk("pt_ready", s_tready, m_tready);
    chk("pt_data", m_tdata, s_tdata);
    chk("pt_keep", m_tkeep, s_tkeep);
    chk("pt_last", m_tlast, s_tlast);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] k, input logic l);
    bit acc;
    int n;
    if (stall) repeat ($urandom_range(0, 2)) tick();
    s_tvalid = 1'b1;
    s_tkeep  = k;
    s_tlast  = l;
    s_tdata  = $urandom;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      acc = m_tready;
      tick();
      if (stall) m_tready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: observed no accept expected accept");
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic start(input logic [7:0] n);
    cfg_start = 1'b1;
    cfg_num   = n;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_report(string tag);
    exp_t e;
    int n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, res_valid, 1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_bytes"}, res_bytes, e.bytes);
      chk({tag, "_beats"}, res_beats, e.beats);
      chk({tag, "_pkts"}, res_packets, e.pkts);
      chk({tag, "_ovf"}, res_overflow, e.ovf);
    end
  endtask

  task automatic consume(string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_cons_valid"}, res_valid, 0);
    chk({tag, "_cons_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 0; s_tlast = 0; s_tdata = 0;
    s_tkeep = 0; m_tready = 1; cfg_start = 0; cfg_start2 = 0;
    cfg_abort = 0; cfg_num = 0; res_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_bytes", res_bytes, 0);
    chk("rst_beats", res_beats, 0);
    chk("rst_pkts", res_packets, 0);
    chk("rst_ovf", res_overflow, 0);

    // Two packets, N=2, ragged final keep.
    exp_q.push_back('{32'd18, 32'd5, 8'd2, 1'b0});
    start(8'd2);
    chk("t1_busy", busy, 1);
    beat(4'hf, 0); beat(4'hf, 0); beat(4'hf, 1);
    beat(4'hf, 0);
    chk("t1_pre_valid", res_valid, 0);
    beat(4'h3, 1);
    chk("t1_rise", res_valid, 1);
    wait_report("t1");
    consume("t1");

    // Arm mid-packet: remainder of the open packet is skipped.
    beat(4'hf, 0); beat(4'hf, 0);
    exp_q.push_back('{32'd1, 32'd1, 8'd1, 1'b0});
    start(8'd1);
    beat(4'hf, 0); beat(4'hf, 1);
    chk("t2_armed_beats", res_beats, 0);
    beat(4'h1, 1);
    wait_report("t2");
    consume("t2");

    // Bubbles and backpressure across a 10-beat packet.
    exp_q.push_back('{32'd40, 32'd10, 8'd1, 1'b0});
    start(8'd1);
    stall = 1;
    for (int i = 0; i < 10; i++) beat(4'hf, 1'(i == 9));
    stall = 0;
    m_tready = 1'b1;
    wait_report("t3");
    consume("t3");

    // Narrow counters saturate and flag overflow.
    cfg_start2 = 1'b1; cfg_num = 8'd1;
    tick();
    cfg_start2 = 1'b0;
    for (int i = 0; i < 5; i++) beat(4'hf, 1'(i == 4));
    chk("t4_valid", res_valid2, 1);
    chk("t4_bytes", res_bytes2, 15);
    chk("t4_beats", res_beats2, 5);
    chk("t4_pkts", res_packets2, 1);
    chk("t4_ovf", res_overflow2, 1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("t4_cons", res_valid2, 0);

    // N=0 reports zeros immediately.
    exp_q.push_back('{32'd0, 32'd0, 8'd0, 1'b0});
    start(8'd0);
    chk("t0_rise", res_valid, 1);
    wait_report("t0");
    consume("t0");

    // Report held under res_ready=0 with start pulses and traffic.
    exp_q.push_back('{32'd4, 32'd1, 8'd1, 1'b0});
    start(8'd1);
    beat(4'hf, 1);
    start(8'd5);
    beat(4'h7, 0); beat(4'hf, 1);
    beat(4'h1, 0); beat(4'hf, 1);
    repeat (15) tick();
    wait_report("t5");
    consume("t5");
    start(8'd3);
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_bytes", res_bytes, 0);
    chk("t5_restart_beats", res_beats, 0);
    chk("t5_restart_pkts", res_packets, 0);

    // Abort during COUNT: partial results, no report.
    beat(4'hf, 0);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_beats", res_beats, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_abort_novalid", res_valid, 0);
      tick();
    end
    beat(4'hf, 1);
    chk("t6_idle_beats", res_beats, 1);

    // Reset mid-COUNT with an open packet.
    start(8'd2);
    beat(4'hf, 1);
    beat(4'hf, 0);
    chk("t7_pre_beats", res_beats, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_valid", res_valid, 0);
    chk("t7_bytes", res_bytes, 0);
    chk("t7_beats", res_beats, 0);
    chk("t7_pkts", res_packets, 0);
    chk("t7_ovf", res_overflow, 0);
    tick();
    chk("t7_novalid", res_valid, 0);

    // in_pkt was cleared, so this beat is a start-of-packet.
    exp_q.push_back('{32'd1, 32'd1, 8'd1, 1'b0});
    start(8'd1);
    beat(4'h1, 1);
    wait_report("t8");
    consume("t8");

    chk("q_empty", exp_q.size(), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_byte_count_ctrl.md
# axis_byte_count_ctrl

Measurement controller for an AXI-Stream link. It sits transparently in the stream path. On command it arms at the next packet boundary and counts accepted beats, kept bytes and packets over a programmed number of whole packets. It then holds the result on a valid/ready report port until software or a downstream block consumes it. It sequences measurement windows so throughput and size checks on DMA streams are repeatable, without hand-gating a free-running counter.

## Interface
Parameters:
- AXIS_BYTES, 4, bytes per beat; tkeep width
- COUNTER_BITS, 32, width of res_bytes and res_beats
- PKT_BITS, 8, width of cfg_num_packets and res_packets

Ports:
- aclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1  upstream handshake
- s_axis_tdata  in  AXIS_BYTES*8  upstream data
- s_axis_tkeep  in  AXIS_BYTES  upstream byte enables
- m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  downstream handshake
- m_axis_tdata  out  AXIS_BYTES*8  downstream data
- m_axis_tkeep  out  AXIS_BYTES  downstream byte enables
- cfg_start  in  1  single-cycle arm request; honoured only in IDLE
- cfg_abort  in  1  return to IDLE from ARMED/COUNT, no report
- cfg_num_packets  in  PKT_BITS  packets per window; sampled on accepted cfg_start
- busy  out  1  high in ARMED or COUNT
- res_valid  out  1  result available (REPORT state)
- res_ready  in  1  result consumed
- res_bytes  out  COUNTER_BITS  sum of set tkeep bits over counted beats
- res_beats  out  COUNTER_BITS  accepted beats counted
- res_packets  out  PKT_BITS  tlast beats counted
- res_overflow  out  1  sticky; a beat or byte counter saturated in this window

## Operation
- Passthrough is purely combinational and independent of state and rst. s_axis_tready = m_axis_tready. m_axis_tvalid, tdata, tkeep and tlast equal their s_axis counterparts.
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- Boundary tracker in_pkt: reset 0. On every accepted beat, in_pkt <= !s_axis_tlast, in all states. An accepted beat with in_pkt==0 is a start-of-packet (SOP) beat.
- States: IDLE, ARMED, COUNT, REPORT. Reset state is IDLE.
- IDLE: on cfg_start, latch N = cfg_num_packets and clear all result counters and res_overflow.
  - If N==0, go to REPORT; it reports all-zero results.
  - Otherwise go to ARMED.
- ARMED: beats that are not SOP are ignored. The first accepted SOP beat is counted and the state moves to COUNT. If that beat has tlast and N==1, the state moves directly to REPORT.
- COUNT: every accepted beat is counted.
  - res_beats += 1.
  - res_bytes += popcount(s_axis_tkeep), where popcount is 0..AXIS_BYTES.
  - If tlast, res_packets += 1.
  - When the accepted beat carries the tlast that makes res_packets equal N, go to REPORT.
- Counter arithmetic: the beat and byte counters saturate at all-ones and never wrap. Any increment that would pass all-ones sets res_overflow. res_packets cannot exceed N, so it needs no saturation.
- REPORT: res_valid=1 and all res_* outputs are held stable. When res_ready=1, go to IDLE next cycle. Counters keep their values until the next accepted cfg_start.
- cfg_abort in ARMED or COUNT goes to IDLE next cycle. Results are left partial, and res_valid is never raised. cfg_abort is ignored in IDLE and REPORT.
- cfg_start outside IDLE is ignored; it is not queued.
- If cfg_start and cfg_abort are high together in IDLE, cfg_start wins.
- rst mid-window: state goes to IDLE, every res_* output and in_pkt clear to 0, and busy goes to 0.

## Timing
- Reset values: busy=0, res_valid=0, res_bytes=0, res_beats=0, res_packets=0, res_overflow=0.
- cfg_start at cycle t in IDLE: busy=1 from t+1. For N==0, res_valid=1 from t+1.
- Final tlast beat accepted at cycle t: res_valid=1 at t+1. At that cycle res_* already include the final beat.
- In REPORT, res_valid && res_ready at cycle t: res_valid=0 at t+1 and state is IDLE. A cfg_start is accepted no earlier than t+1.
- Counter updates are registered; values are visible the cycle after acceptance.
- No backpressure is ever inserted on the stream. The zero-latency passthrough must hold in every state.

## Test plan
- Arm with N=2 at idle line, AXIS_BYTES=4. Send packets of 3 beats and 2 beats, full keep, last beat keep=4'b0011 -> res_beats=5, res_bytes=18, res_packets=2. res_valid rises the cycle after the second tlast.
- Arm mid-packet: 2 beats of a 4-beat packet already passed, then a 1-beat packet (keep=4'b0001), N=1 -> remainder of the first packet ignored; res_beats=1, res_bytes=1, res_packets=1.
- Stall and bubble: random tvalid and tready gaps during a 10-beat full-keep packet, N=1 -> res_beats=10, res_bytes=40. m_axis mirrors s_axis every cycle.
- COUNTER_BITS=4, N=1, one 5-beat full-keep packet -> res_bytes=15 (saturated), res_beats=5, res_overflow=1.
- Hold res_ready=0 for 20 cycles in REPORT while pulsing cfg_start and streaming packets -> results unchanged, start ignored. After res_ready=1, IDLE next cycle; new cfg_start clears counters.
- cfg_abort during COUNT, then rst asserted during a later COUNT -> no res_valid pulse in either case. After rst, all outputs are 0 and busy=0.
